// File: rtl/frame_arb_pkg.sv
// Shared state type and round-robin helper for frame_stream_arbiter.
package frame_arb_pkg;

    localparam int unsigned MAX_SRC = 8;
    localparam int unsigned SEL_W   = $clog2(MAX_SRC);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DRAIN,
        GAP
    } arb_state_e;

    // First requester strictly after last (mod n); keeps last when nobody requests.
    function automatic logic [SEL_W-1:0] rr_next(input logic [MAX_SRC-1:0] req,
                                                 input logic [SEL_W-1:0]   last,
                                                 input int unsigned        n);
        logic [SEL_W-1:0] win;
        int unsigned      idx;
        win = last;
        for (int unsigned k = MAX_SRC; k >= 1; k--) begin
            if (k <= n) begin
                idx = (32'(last) + k) % n;
                if (req[idx[SEL_W-1:0]]) win = idx[SEL_W-1:0];
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/frame_stream_arbiter_rr_pick.sv
// Combinational rotating priority encoder: winner after the last grant plus any-request flag.
module rr_pick
    import frame_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0]         req_i,
    input  logic [$clog2(NUM_SRC)-1:0] last_i,
    output logic [$clog2(NUM_SRC)-1:0] win_o,
    output logic                       any_o
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    assign win_o = IDX_W'(rr_next(MAX_SRC'(req_i), SEL_W'(last_i), NUM_SRC));
    assign any_o = |req_i;

endmodule

// File: rtl/frame_stream_arbiter.sv
// Frame-granular round-robin arbiter with programmable inter-frame gap and runaway-frame truncation.
// Optional per-source frame / truncation counters under FRAME_STREAM_ARBITER_STATS_EN.
module frame_stream_arbiter
    import frame_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned GAP_W      = 9,
    parameter int unsigned BEAT_W     = 14
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    input  logic [NUM_SRC-1:0]              S_AXIS_tvalid,
    input  logic [NUM_SRC-1:0]              S_AXIS_tlast,
    output logic [NUM_SRC-1:0]              S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]           M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0]         M_AXIS_tkeep,
    output logic                            M_AXIS_tvalid,
    output logic                            M_AXIS_tlast,
    input  logic                            M_AXIS_tready,
    input  logic [GAP_W-1:0]                gap_cycles,
    input  logic [BEAT_W-1:0]               max_beats,
    output logic [$clog2(NUM_SRC)-1:0]      grant_id,
    output logic                            busy,
    output logic                            trunc_pulse
`ifdef FRAME_STREAM_ARBITER_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]           frame_count,
    output logic [15:0]                     trunc_count
`endif
);

    localparam int unsigned IDX_W  = $clog2(NUM_SRC);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;
    localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d, pick;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              any_req, out_hs, trunc_hit, frame_end;

    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [KEEP_W-1:0]     src_keep [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = S_AXIS_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign src_keep[i] = S_AXIS_tkeep[i*KEEP_W +: KEEP_W];
    end

    rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
        .req_i  (S_AXIS_tvalid),
        .last_i (grant_q),
        .win_o  (pick),
        .any_o  (any_req)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        beat_d        = beat_q;
        gap_d         = gap_q;
        S_AXIS_tready = '0;
        M_AXIS_tdata  = '0;
        M_AXIS_tkeep  = '0;
        M_AXIS_tvalid = 1'b0;
        M_AXIS_tlast  = 1'b0;
        trunc_pulse   = 1'b0;
        out_hs        = 1'b0;
        trunc_hit     = 1'b0;
        frame_end     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                trunc_hit = (max_beats != '0) && (beat_q == max_beats - BEAT_W'(1))
                            && !S_AXIS_tlast[grant_q];
                M_AXIS_tdata           = src_data[grant_q];
                M_AXIS_tkeep           = src_keep[grant_q];
                M_AXIS_tvalid          = S_AXIS_tvalid[grant_q];
                M_AXIS_tlast           = S_AXIS_tlast[grant_q] | trunc_hit;
                S_AXIS_tready[grant_q] = M_AXIS_tready;
                out_hs                 = S_AXIS_tvalid[grant_q] & M_AXIS_tready;
                if (out_hs) begin
                    if (beat_q != BEAT_MAX) beat_d = beat_q + BEAT_W'(1);
                    trunc_pulse = trunc_hit;
                    if (trunc_hit) state_d = DRAIN;
                    else frame_end = S_AXIS_tlast[grant_q];
                end
            end
            // Swallow the remainder of a truncated frame without forwarding it.
            DRAIN: begin
                S_AXIS_tready[grant_q] = 1'b1;
                frame_end = S_AXIS_tvalid[grant_q] & S_AXIS_tlast[grant_q];
            end
            GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (frame_end) begin
            if (gap_cycles != '0) begin
                state_d = GAP;
                gap_d   = gap_cycles;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            grant_q <= IDX_W'(NUM_SRC - 1);
            beat_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT) || (state_q == DRAIN);

`ifdef FRAME_STREAM_ARBITER_STATS_EN
    logic [15:0] frame_cnt_q [NUM_SRC];
    logic [15:0] trunc_cnt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_SRC; i++) frame_cnt_q[i] <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (out_hs && M_AXIS_tlast) frame_cnt_q[grant_q] <= frame_cnt_q[grant_q] + 16'd1;
            if (trunc_pulse) trunc_cnt_q <= trunc_cnt_q + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_stats
        assign frame_count[i*16 +: 16] = frame_cnt_q[i];
    end
    assign trunc_count = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Randomized scoreboard bench for frame_stream_arbiter against a frame-level round-robin model.
module tb_frame_stream_arbiter;

    localparam int unsigned NS = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned GW = 9;
    localparam int unsigned BW = 14;
    localparam int unsigned IW = $clog2(NS);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } sbeat_t;

    typedef struct packed {
        logic [IW-1:0] src;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          trunc;
    } obeat_t;

    logic            clk = 1'b0;
    logic            ARESET;
    logic [NS*DW-1:0] S_tdata;
    logic [NS*KW-1:0] S_tkeep;
    logic [NS-1:0]   S_tvalid, S_tlast, S_tready;
    logic [DW-1:0]   M_tdata;
    logic [KW-1:0]   M_tkeep;
    logic            M_tvalid, M_tlast, M_tready;
    logic [GW-1:0]   gap_cycles;
    logic [BW-1:0]   max_beats;
    logic [IW-1:0]   grant_id;
    logic            busy, trunc_pulse;
`ifdef FRAME_STREAM_ARBITER_STATS_EN
    logic [NS*16-1:0] frame_count;
    logic [15:0]      trunc_count;
`endif

    always #5 clk = ~clk;

    frame_stream_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .GAP_W(GW), .BEAT_W(BW)) dut (
        .ACLK          (clk),
        .ARESET        (ARESET),
        .S_AXIS_tdata  (S_tdata),
        .S_AXIS_tkeep  (S_tkeep),
        .S_AXIS_tvalid (S_tvalid),
        .S_AXIS_tlast  (S_tlast),
        .S_AXIS_tready (S_tready),
        .M_AXIS_tdata  (M_tdata),
        .M_AXIS_tkeep  (M_tkeep),
        .M_AXIS_tvalid (M_tvalid),
        .M_AXIS_tlast  (M_tlast),
        .M_AXIS_tready (M_tready),
        .gap_cycles    (gap_cycles),
        .max_beats     (max_beats),
        .grant_id      (grant_id),
        .busy          (busy),
        .trunc_pulse   (trunc_pulse)
`ifdef FRAME_STREAM_ARBITER_STATS_EN
        ,
        .frame_count   (frame_count),
        .trunc_count   (trunc_count)
`endif
    );

    sbeat_t src_q [NS][$];
    int     frm_len [NS][$];
    obeat_t exp_q [$];
    logic [NS-1:0] hs;
    logic [NS-1:0] sof;
    int     ready_mode, bubbles;
    int     exp_fc [NS];
    int     exp_tc;
    int     checks = 0;
    int     passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: frame-level round robin over sources that still hold frames.
    task automatic build_expected();
        int pos [NS];
        int fidx [NS];
        int last, s, len;
        bit found;
        sbeat_t b;
        obeat_t o;
        last = NS - 1;
        exp_tc = 0;
        for (int i = 0; i < NS; i++) begin
            pos[i] = 0;
            fidx[i] = 0;
            exp_fc[i] = 0;
        end
        forever begin
            found = 0;
            s = 0;
            for (int k = NS; k >= 1; k--) begin
                if (fidx[(last + k) % NS] < frm_len[(last + k) % NS].size()) begin
                    s = (last + k) % NS;
                    found = 1;
                end
            end
            if (!found) break;
            len = frm_len[s][fidx[s]];
            for (int k = 0; k < len; k++) begin
                b = src_q[s][pos[s] + k];
                o.src = IW'(s);
                o.data = b.data;
                o.keep = b.keep;
                if (max_beats != 0 && k == int'(max_beats) - 1 && k != len - 1) begin
                    o.last = 1'b1;
                    o.trunc = 1'b1;
                    exp_q.push_back(o);
                    exp_tc++;
                    break;
                end
                o.last = b.last;
                o.trunc = 1'b0;
                exp_q.push_back(o);
            end
            exp_fc[s]++;
            pos[s] += len;
            fidx[s]++;
            last = s;
        end
    endtask

    task automatic add_frame(input int s, input int len);
        sbeat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = $urandom;
            b.keep = KW'($urandom);
            b.last = (k == len - 1);
            src_q[s].push_back(b);
        end
        frm_len[s].push_back(len);
    endtask

    task automatic update_drive();
        sbeat_t b;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                b = src_q[i].pop_front();
                sof[i] = b.last;
            end
            if (src_q[i].size() == 0) begin
                S_tvalid[i] = 1'b0;
            end else begin
                // Valid stays high until accepted; a frame's first beat is never withheld.
                if (hs[i] || !S_tvalid[i])
                    S_tvalid[i] = sof[i] || (bubbles == 0) || ($urandom_range(0, 3) != 0);
                b = src_q[i][0];
                S_tdata[i*DW +: DW] = b.data;
                S_tkeep[i*KW +: KW] = b.keep;
                S_tlast[i] = b.last;
            end
        end
        hs = '0;
        case (ready_mode)
            0: M_tready = 1'b1;
            1: M_tready = ~M_tready;
            default: M_tready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic start_phase(input int g, input int m, input int r, input int bub);
        @(posedge clk); #1;
        ARESET = 1'b1;
        @(posedge clk); #1;
        ARESET = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            frm_len[i].delete();
        end
        exp_q.delete();
        sof = '1;
        hs = '0;
        S_tvalid = '0;
        S_tlast = '0;
        S_tdata = '0;
        S_tkeep = '0;
        M_tready = 1'b0;
        gap_cycles = GW'(g);
        max_beats = BW'(m);
        ready_mode = r;
        bubbles = bub;
        check("rst_mvalid", 64'(M_tvalid), 0);
        check("rst_mlast", 64'(M_tlast), 0);
        check("rst_mdata", 64'(M_tdata), 0);
        check("rst_tready", 64'(S_tready), 0);
        check("rst_grant", 64'(grant_id), 64'(NS - 1));
        check("rst_busy", 64'(busy), 0);
        check("rst_trunc", 64'(trunc_pulse), 0);
    endtask

    task automatic run_phase(input int abort_at);
        int n_out, cyc;
        bit empty;
        n_out = 0;
        cyc = 0;
        build_expected();
        forever begin
            @(posedge clk); #1;
            update_drive();
            empty = (exp_q.size() == 0);
            for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) empty = 0;
            if (empty) break;
            if (++cyc > 4000) begin
                check("phase_timeout", 1, 0);
                break;
            end
            @(negedge clk);
            hs = S_tvalid & S_tready;
            if (M_tvalid && M_tready) n_out++;
            if (abort_at > 0 && n_out >= abort_at) return;
        end
        check("leftover_beats", 64'(exp_q.size()), 0);
`ifdef FRAME_STREAM_ARBITER_STATS_EN
        for (int i = 0; i < NS; i++)
            check("frame_count", 64'(frame_count[i*16 +: 16]), 64'(exp_fc[i]));
        check("trunc_count", 64'(trunc_count), 64'(exp_tc));
`endif
    endtask

    // Monitor: pops the scoreboard on each output handshake and watches gaps / tready.
    initial begin : monitor
        obeat_t a, e;
        bit gwait;
        int gcnt;
        gwait = 0;
        gcnt = 0;
        forever begin
            @(negedge clk);
            if (ARESET) begin
                gwait = 0;
            end else begin
                if (S_tready != '0)
                    check("tready_grant", 64'(S_tready), 64'(NS'(1) << grant_id));
                if (gwait) begin
                    if (busy) begin
                        check("gap_len", 64'(gcnt), 64'(gap_cycles) + 1);
                        gwait = 0;
                    end else begin
                        gcnt++;
                        if (S_tready != '0) check("gap_tready", 64'(S_tready), 0);
                    end
                end
                if (M_tvalid && M_tready) begin
                    a = {grant_id, M_tdata, M_tkeep, M_tlast, trunc_pulse};
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 64'(a), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", 64'(a), 64'(e));
                        if (e.last && !e.trunc && exp_q.size() != 0) begin
                            gwait = 1;
                            gcnt = 0;
                        end
                    end
                end else begin
                    check("trunc_idle", 64'(trunc_pulse), 0);
                end
            end
        end
    end

    initial begin
        ARESET = 1'b1;
        S_tdata = '0;
        S_tkeep = '0;
        S_tvalid = '0;
        S_tlast = '0;
        M_tready = 1'b0;
        gap_cycles = '0;
        max_beats = '0;
        ready_mode = 0;
        bubbles = 0;
        hs = '0;
        sof = '1;
        repeat (2) @(posedge clk);

        // Two sources back to back, no gap, always ready.
        start_phase(0, 0, 0, 0);
        for (int f = 0; f < 3; f++) begin
            add_frame(0, 4);
            add_frame(1, 4);
        end
        run_phase(0);

        // Single source with a 3-cycle gap.
        start_phase(3, 0, 2, 1);
        add_frame(0, 3);
        add_frame(0, 5);
        add_frame(0, 1);
        run_phase(0);

        // Truncation at 4 beats.
        start_phase(1, 4, 0, 0);
        add_frame(0, 2);
        add_frame(1, 7);
        add_frame(0, 5);
        run_phase(0);

        // Output ready toggling every cycle.
        start_phase(0, 0, 1, 0);
        add_frame(0, 6);
        add_frame(1, 6);
        run_phase(0);

        // Abandon a frame at its third beat; the next phase's reset lands mid-frame.
        start_phase(0, 0, 0, 0);
        add_frame(0, 6);
        add_frame(1, 4);
        run_phase(2);

        start_phase(2, 0, 2, 1);
        add_frame(0, 3);
        add_frame(1, 3);
        add_frame(2, 2);
        run_phase(0);

        // Randomized traffic across all sources.
        for (int p = 0; p < 5; p++) begin
            int mb;
            case ($urandom_range(0, 2))
                0: mb = 0;
                1: mb = 3;
                default: mb = 5;
            endcase
            start_phase(int'($urandom_range(0, 4)), mb, 2, 1);
            for (int s = 0; s < NS; s++) begin
                int nf;
                nf = int'($urandom_range(1, 4));
                for (int f = 0; f < nf; f++) add_frame(s, int'($urandom_range(1, 8)));
            end
            run_phase(0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
